// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the fetch stage: opcode classes, fetch-buffer entry layout
// and the fetch control states.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [6:0] {
        RTYPE       = 7'b0110011,
        ITYPE_IMM   = 7'b0010011,
        ITYPE_LD    = 7'b0000011,
        ITYPE_JALR  = 7'b1100111,
        STYPE       = 7'b0100011,
        BTYPE       = 7'b1100011,
        UTYPE_LUI   = 7'b0110111,
        UTYPE_AUIPC = 7'b0010111,
        JTYPE       = 7'b1101111
    } instr_types_e;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        illegal;
    } fetch_entry_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            RTYPE, ITYPE_IMM, ITYPE_LD, ITYPE_JALR, STYPE,
            BTYPE, UTYPE_LUI, UTYPE_AUIPC, JTYPE: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO with combinational head, synchronous clear and simultaneous
// push/pop when full. Storage is not reset; only pointers and count are.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches, buffers responses and
// flushes buffered and in-flight work on execute redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_illegal
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   pc, rsp_pc;
    logic [CW-1:0] inflight, discard, buf_count, tag_count;
    logic [CW-1:0] inflight_nxt, discard_nxt, discard_redir;
    logic          buf_full, buf_empty, tag_full, tag_empty;
    logic          req_fire, rsp_fire, drop_rsp, keep_rsp, pop, room;
    fetch_entry_t  buf_wdata, buf_rdata;

    // Outstanding work (in flight plus buffered) is capped at the buffer depth.
    assign room           = ({1'b0, inflight} + {1'b0, buf_count}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid = (state != BOOT) && (discard == '0) && room && !redirect_valid;
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_fire = imem_rsp_valid;
    assign drop_rsp = rsp_fire && (discard != '0);
    assign keep_rsp = rsp_fire && (discard == '0) && !redirect_valid;
    assign pop      = out_valid & out_ready;

    assign inflight_nxt  = inflight + CW'(req_fire) - CW'(rsp_fire && (discard == '0));
    assign discard_nxt   = discard - CW'(drop_rsp);
    assign discard_redir = discard + inflight - CW'(rsp_fire);

    always_comb begin
        buf_wdata.pc      = rsp_pc;
        buf_wdata.instr   = imem_rsp_data;
        buf_wdata.illegal = !is_legal_opcode(imem_rsp_data[6:0]) || (imem_rsp_data[1:0] != 2'b11);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC & INSTR_ALIGN_MASK;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & INSTR_ALIGN_MASK;
            inflight <= '0;
            discard  <= discard_redir;
            state    <= (discard_redir != '0) ? FLUSH : RUN;
        end else begin
            if (req_fire) pc <= pc + 32'd4;
            inflight <= inflight_nxt;
            discard  <= discard_nxt;
            state    <= (state == BOOT || discard_nxt == '0) ? RUN : FLUSH;
        end
    end

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep_rsp),
        .pop   (pop),
        .clear (redirect_valid),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // Issued addresses, consumed in order as kept responses return.
    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (keep_rsp),
        .clear (redirect_valid),
        .wdata (pc),
        .rdata (rsp_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    assign out_valid   = !buf_empty;
    assign out_instr   = buf_empty ? NOP_INSTR : buf_rdata.instr;
    assign out_pc      = buf_empty ? RESET_PC : buf_rdata.pc;
    assign out_illegal = !buf_empty && buf_rdata.illegal;

    a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        tag_count == inflight);
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        !(keep_rsp && tag_empty));
    a_req_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_fire && tag_full));
    a_buf_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(keep_rsp && buf_full && !pop));

endmodule
